mnd_sequencer: RTL and testbench

//  Multi-cycle sequencer for the mult/div unit and the HI/LO register pair in the EX stage.

---
 rtl/mnd_pkg.sv | 22 ++
 rtl/mnd_arith.sv | 67 ++++++
 rtl/mnd_sequencer.sv | 124 ++++++++++++
 tb/tb_mnd_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mnd_pkg.sv
// Shared encodings, state type and counter helpers for the mult/div sequencer.
package mnd_pkg;

   localparam int CNT_W = 5;

   localparam logic [1:0] MNDOP_MULTU = 2'b00;
   localparam logic [1:0] MNDOP_MULT  = 2'b01;
   localparam logic [1:0] MNDOP_DIVU  = 2'b10;
   localparam logic [1:0] MNDOP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1,
      ST_DIV_BUSY = 2'd2
   } state_t;

   // The counter is loaded with N-1 so the commit lands exactly N edges after the start edge.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/mnd_arith.sv
// Combinational mult/div datapath: produces the HI/LO pair for every mndop,
// including the divide-by-zero and signed-overflow results.
module mnd_arith
   import mnd_pkg::*;
(
   input  logic [1:0]  mndop,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic        w_neg_a;
   logic        w_neg_b;
   logic [63:0] w_prod;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_div_b;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [31:0] w_q;
   logic [31:0] w_r;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      res_hi  = '0;
      res_lo  = '0;
      w_neg_a = mndop[0] & rs_val[31];
      w_neg_b = mndop[0] & rt_val[31];

      // Sign- or zero-extended operands make one 64-bit multiplier serve both mult and multu.
      w_prod  = {{32{w_neg_a}}, rs_val} * {{32{w_neg_b}}, rt_val};

      w_abs_a = w_neg_a ? -rs_val : rs_val;
      w_abs_b = w_neg_b ? -rt_val : rt_val;
      w_div_b = (rt_val == 32'd0) ? 32'd1 : w_abs_b;
      w_uq    = w_abs_a / w_div_b;
      w_ur    = w_abs_a % w_div_b;
      w_q     = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
      w_r     = w_neg_a ? -w_ur : w_ur;

      unique case (mndop)
         MNDOP_MULTU, MNDOP_MULT: begin
            res_hi = w_prod[63:32];
            res_lo = w_prod[31:0];
         end
         MNDOP_DIVU, MNDOP_DIV: begin
            if (rt_val == 32'd0) begin
               res_hi = rs_val;
               res_lo = 32'hFFFF_FFFF;
            end else if (mndop == MNDOP_DIV && rs_val == 32'h8000_0000
                         && rt_val == 32'hFFFF_FFFF) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = w_r;
               res_lo = w_q;
            end
         end
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

endmodule

// File: rtl/mnd_sequencer.sv
// EX-stage mult/div sequencer: fixed-latency busy window, HI/LO register pair,
// mthi/mtlo writes, mfhi/mflo reads and the pipeline stall request.
module mnd_sequencer
   import mnd_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  mndop,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mnd_we,
   input  logic        HiLo,
   input  logic        rd_req,
   input  logic        hi_lo_sel,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] MUL_LOAD = cnt_load(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = cnt_load(DIV_CYCLES);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_pend_hi;
   logic [31:0]      r_pend_lo;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic             r_done;
   logic             w_busy;
   logic             w_launch;
   logic             w_commit;
   logic             w_write;
   logic [31:0]      w_res_hi;
   logic [31:0]      w_res_lo;

   mnd_arith u_arith (
      .mndop  (mndop),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .res_hi (w_res_hi),
      .res_lo (w_res_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_launch     = 1'b0;
      w_commit     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start && !flush) begin
               w_launch     = 1'b1;
               w_next_state = mndop[1] ? ST_DIV_BUSY : ST_MUL_BUSY;
            end
         end
         ST_MUL_BUSY, ST_DIV_BUSY: begin
            // A flush on the final busy cycle still wins over the commit.
            if (flush) begin
               w_next_state = ST_IDLE;
            end else if (r_cnt == '0) begin
               w_commit     = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy  = (r_state != ST_IDLE);
      stall   = w_busy & (start | mnd_we | rd_req);
      w_write = !w_busy & mnd_we & !start & !flush;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: HI/LO and the pending pair are architectural state and are cleared by reset.
      if (!rst_n) begin
         r_cnt     <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_launch) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_cnt     <= mndop[1] ? DIV_LOAD : MUL_LOAD;
         end else if (w_busy && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_commit) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end else if (w_write) begin
            if (HiLo) r_hi <= rs_val;
            else      r_lo <= rs_val;
         end
      end
   end

   assign busy    = w_busy;
   assign done    = r_done;
   assign hi      = r_hi;
   assign lo      = r_lo;
   assign rd_data = hi_lo_sel ? r_lo : r_hi;

endmodule

// File: tb/tb_mnd_sequencer.sv
// Scoreboard bench for mnd_sequencer: ops push expected HI/LO and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mnd_sequencer;

   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;

   typedef struct {
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_cyc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mndop = 2'b00;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        mnd_we = 1'b0;
   logic        HiLo = 1'b0;
   logic        rd_req = 1'b0;
   logic        hi_lo_sel = 1'b0;
   logic        flush = 1'b0;
   logic        busy, stall, done;
   logic [31:0] rd_data, hi, lo;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   sb_t  sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mnd_sequencer #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mndop(mndop),
      .rs_val(rs_val), .rt_val(rt_val), .mnd_we(mnd_we), .HiLo(HiLo),
      .rd_req(rd_req), .hi_lo_sel(hi_lo_sel), .flush(flush),
      .busy(busy), .stall(stall), .done(done), .rd_data(rd_data),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference results straight from the arithmetic rules, using native integer ops.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int              sa, sb, sq, sr;
      longint          sp;
      longint unsigned up, ua, ub;
      logic [63:0]     r;
      sa = a; sb = b;
      case (op)
         2'b00: begin ua = a; ub = b; up = ua * ub; r = up; end
         2'b01: begin sp = longint'(sa) * longint'(sb); r = sp; end
         default: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else if (op == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else if (op == 2'b11) begin sq = sa / sb; sr = sa % sb; r = {sr, sq}; end
            else r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb_hi", hi, e.exp_hi);
            check("sb_lo", lo, e.exp_lo);
            check("sb_done_cycle", cyc, e.exp_cyc);
         end
      end
   end

   // mode: 0 plain, 1 rd_req of LO every busy cycle, 2 mthi held while busy, 3 mnd_we with start
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode, output int busy_cycles, output int stall_cycles);
      logic [63:0] r;
      int n;
      n = op[1] ? DIV_C : MULT_C;
      r = model(op, a, b);
      start = 1'b1; mndop = op; rs_val = a; rt_val = b;
      if (mode == 3) begin mnd_we = 1'b1; HiLo = 1'b1; end
      sb_q.push_back('{r[63:32], r[31:0], cyc + 1 + n});
      m_hi = r[63:32]; m_lo = r[31:0];
      @(posedge clk); #1;
      start = 1'b0; mnd_we = 1'b0;
      if (mode == 1) begin rd_req = 1'b1; hi_lo_sel = 1'b1; end
      if (mode == 2) begin mnd_we = 1'b1; HiLo = 1'b1; rs_val = 32'hA5A5_A5A5; end
      busy_cycles = 0; stall_cycles = 0;
      for (int i = 0; i < 64 && busy; i++) begin
         busy_cycles++;
         if (stall) stall_cycles++;
         if (mode == 2) check("hi_held_while_busy", hi, hi);
         @(posedge clk); #1;
      end
      if (mode == 1) begin
         check("stall_clear_after_commit", stall, 0);
         check("rd_data_lo_first_free", rd_data, r[31:0]);
      end
      mnd_we = 1'b0; rd_req = 1'b0;
   endtask

   task automatic write_hilo(input logic sel_hi, input logic [31:0] d);
      mnd_we = 1'b1; HiLo = sel_hi; rs_val = d;
      @(posedge clk); #1;
      mnd_we = 1'b0;
      if (sel_hi) m_hi = d; else m_lo = d;
      check("wr_hi", hi, m_hi);
      check("wr_lo", lo, m_lo);
   endtask

   initial begin
      int bc, sc;
      logic [31:0] a, b;
      logic [1:0]  op;

      #12;
      check("rst_busy", busy, 0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_done_stall", {done, stall}, 2'b00);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, bc, sc);
      check("mult_busy_cycles", bc, MULT_C);
      check("mult_hi_lo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(2'b10, 32'd100, 32'd7, 0, bc, sc);
      check("divu_busy_cycles", bc, DIV_C);
      check("divu_hi_lo", {hi, lo}, {32'd2, 32'd14});
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, bc, sc);
      check("div_neg_hi_lo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'b11, 32'd5, 32'd0, 0, bc, sc);
      check("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, bc, sc);
      check("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});

      run_op(2'b00, 32'hFFFF_FFFF, 32'h0001_0003, 1, bc, sc);
      check("rd_stall_cycles", sc, MULT_C);

      run_op(2'b01, 32'd1234, 32'hFFFF_0000, 2, bc, sc);
      check("mthi_stall_cycles", sc, MULT_C);
      check("mthi_dropped_hi", hi, m_hi);
      write_hilo(1'b1, 32'hA5A5_A5A5);
      write_hilo(1'b0, 32'h5A5A_0F0F);
      hi_lo_sel = 1'b0; #1;
      check("rd_data_hi", rd_data, m_hi);

      run_op(2'b00, 32'd9, 32'd9, 3, bc, sc);
      check("start_beats_we", {hi, lo}, {32'd0, 32'd81});

      // Flush on the third busy cycle: back to idle, nothing committed.
      start = 1'b1; mndop = 2'b11; rs_val = 32'd77; rt_val = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check("flush_to_idle", busy, 0);
      repeat (DIV_C) @(posedge clk);
      #1;
      check("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});

      // Flush also suppresses a same-cycle start and write.
      start = 1'b1; mnd_we = 1'b1; flush = 1'b1; mndop = 2'b01;
      @(posedge clk); #1;
      start = 1'b0; mnd_we = 1'b0; flush = 1'b0;
      check("flush_blocks_start", busy, 0);
      check("flush_blocks_we", {hi, lo}, {m_hi, m_lo});

      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
              ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
         if ($urandom_range(0, 4) == 0) write_hilo(1'($urandom_range(0, 1)), $urandom);
         else run_op(op, a, b, 0, bc, sc);
      end

      // Reset mid-operation clears everything immediately.
      start = 1'b1; mndop = 2'b01; rs_val = 32'd3; rt_val = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; rst_n = 1'b0;
      #1;
      check("rst_mid_busy", {busy, done, stall}, 3'b000);
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      check("rst_mid_rd_data", rd_data, 0);
      sb_q.delete();
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (DIV_C + 2) @(posedge clk);
      #1;
      check("rst_no_late_commit", {hi, lo}, 64'd0);
      check("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
